// File: rtl/gmii_rx_pkg.sv
// Shared types and constants for the GMII receive framer and its CRC helper.
package gmii_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        DATA,
        END,
        DROP
    } state_e;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY      = 32'hEDB8_8320;
    localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB_20E3;
    localparam int          LEN_W         = 11;
    localparam int          CNT_W         = 16;
    localparam logic [2:0]  PRE_MAX       = 3'd7;

    function automatic logic [LEN_W-1:0] len_inc(input logic [LEN_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/crc32_d8.sv
// Combinational byte-wide step of the reflected Ethernet CRC-32 (LSB first).
// Shared with the TX framer, so it carries no state of its own.
module crc32_d8
    import gmii_rx_pkg::*;
(
    input  logic [31:0] crc_i,
    input  logic [7:0]  data_i,
    output logic [31:0] crc_o
);

    logic [31:0] c;

    always_comb begin
        c = crc_i ^ {24'd0, data_i};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        crc_o = c;
    end

endmodule

// File: rtl/gmii_rx_framer.sv
// GMII receive framer: strips preamble/SFD, streams frame bytes, checks FCS and length.
// Optional RX_STRIP_FCS_EN withholds the trailing four FCS bytes from the output stream.
//
// state | meaning
// IDLE  | waiting for the first preamble byte
// PRE   | counting preamble bytes, expecting SFD
// DATA  | capturing frame bytes until dv falls
// END   | eop cycle; input byte evaluated as in IDLE
// DROP  | malformed preamble, discard until dv falls
module gmii_rx_framer
    import gmii_rx_pkg::*;
#(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             gmii_rx_dv,
    input  logic [7:0]       gmii_rxd,
    output logic             rx_valid,
    output logic [7:0]       rx_data,
    output logic             rx_sop,
    output logic             rx_eop,
    output logic             rx_err,
    output logic [LEN_W-1:0] rx_len,
    output logic [CNT_W-1:0] good_cnt,
    output logic [CNT_W-1:0] bad_cnt
);

    localparam logic [LEN_W-1:0] MIN_LEN_L = LEN_W'(MIN_LEN);
    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    state_e           state_q;
    logic [2:0]       pre_cnt_q;
    logic [31:0]      crc_q;
    logic [31:0]      crc_d;
    logic [LEN_W-1:0] len_q;
    logic             rx_valid_q;
    logic [7:0]       rx_data_q;
    logic             rx_sop_q;
    logic             rx_eop_q;
    logic             rx_err_q;
    logic [LEN_W-1:0] rx_len_q;
    logic [CNT_W-1:0] good_cnt_q;
    logic [CNT_W-1:0] bad_cnt_q;
    logic             frame_err;
`ifdef RX_STRIP_FCS_EN
    logic [3:0][7:0]  dly_q;
`endif

    crc32_d8 u_crc32_d8 (
        .crc_i  (crc_q),
        .data_i (gmii_rxd),
        .crc_o  (crc_d)
    );

    assign frame_err = (crc_q != CRC_RESIDUE) | (len_q < MIN_LEN_L) | (len_q > MAX_LEN_L);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pre_cnt_q  <= '0;
            crc_q      <= CRC_INIT;
            len_q      <= '0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
            rx_sop_q   <= 1'b0;
            rx_eop_q   <= 1'b0;
            rx_err_q   <= 1'b0;
            rx_len_q   <= '0;
            good_cnt_q <= '0;
            bad_cnt_q  <= '0;
`ifdef RX_STRIP_FCS_EN
            dly_q      <= '0;
`endif
        end else begin
            rx_valid_q <= 1'b0;
            rx_sop_q   <= 1'b0;
            rx_eop_q   <= 1'b0;
            rx_err_q   <= 1'b0;
            rx_len_q   <= '0;
            case (state_q)
                // END behaves like IDLE so a frame starting in the eop cycle loses nothing
                IDLE, END: begin
                    if (gmii_rx_dv) begin
                        if (gmii_rxd == PREAMBLE_BYTE) begin
                            state_q   <= PRE;
                            pre_cnt_q <= 3'd1;
                        end else begin
                            state_q <= DROP;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                PRE: begin
                    if (!gmii_rx_dv) begin
                        state_q <= IDLE;
                    end else if (gmii_rxd == SFD_BYTE) begin
                        state_q <= DATA;
                        crc_q   <= CRC_INIT;
                        len_q   <= '0;
                    end else if (gmii_rxd == PREAMBLE_BYTE && pre_cnt_q < PRE_MAX) begin
                        pre_cnt_q <= pre_cnt_q + 3'd1;
                    end else begin
                        state_q <= DROP;
                    end
                end
                DATA: begin
                    if (gmii_rx_dv) begin
                        crc_q <= crc_d;
                        len_q <= len_inc(len_q);
`ifdef RX_STRIP_FCS_EN
                        dly_q <= {dly_q[2:0], gmii_rxd};
                        if (len_q >= LEN_W'(4)) begin
                            rx_valid_q <= 1'b1;
                            rx_data_q  <= dly_q[3];
                            rx_sop_q   <= (len_q == LEN_W'(4));
                        end
`else
                        rx_valid_q <= 1'b1;
                        rx_data_q  <= gmii_rxd;
                        rx_sop_q   <= (len_q == '0);
`endif
                    end else begin
                        state_q  <= END;
                        rx_eop_q <= 1'b1;
                        rx_err_q <= frame_err;
                        rx_len_q <= len_q;
                        if (frame_err) begin
                            bad_cnt_q <= cnt_inc(bad_cnt_q);
                        end else begin
                            good_cnt_q <= cnt_inc(good_cnt_q);
                        end
                        crc_q <= CRC_INIT;
                        len_q <= '0;
                    end
                end
                DROP: begin
                    if (!gmii_rx_dv) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;
    assign rx_sop   = rx_sop_q;
    assign rx_eop   = rx_eop_q;
    assign rx_err   = rx_err_q;
    assign rx_len   = rx_len_q;
    assign good_cnt = good_cnt_q;
    assign bad_cnt  = bad_cnt_q;

endmodule

// File: doc/gmii_rx_framer.md
Name: gmii_rx_framer

Overview:
Consumes the byte-wide GMII receive stream (gmii_rx_clk domain) produced by the RGMII-to-GMII receive stage. Strips preamble/SFD and delivers frame bytes with start/end markers. Checks Ethernet CRC-32 and length, and keeps good/bad frame counters. Feeds the MAC/UDP receive logic in the same clock domain.

Parameters:
MIN_LEN, 64, minimum legal frame length in bytes (DA through FCS)
MAX_LEN, 1518, maximum legal frame length in bytes (DA through FCS)

Ports:
clk  input  1  GMII receive clock (gmii_rx_clk), 125 MHz
rst_n  input  1  asynchronous active-low reset
gmii_rx_dv  input  1  GMII receive data valid
gmii_rxd  input  8  GMII receive data
rx_valid  output  1  rx_data holds a frame byte this cycle
rx_data  output  8  frame byte (DA first)
rx_sop  output  1  with rx_valid, marks first byte of frame
rx_eop  output  1  one-cycle end-of-frame strobe; rx_valid is low in this cycle
rx_err  output  1  valid only with rx_eop: CRC, runt or oversize error
rx_len  output  11  valid only with rx_eop: byte count DA..FCS, saturates at 2047
good_cnt  output  16  good frames received, saturating
bad_cnt  output  16  errored frames received, saturating

Behaviour:
- Reset (rst_n low, async): state IDLE; all outputs 0; CRC register 0xFFFFFFFF; counters 0.
- FSM:
  - IDLE: dv=1 and rxd=0x55 -> PRE (preamble count=1). dv=1 and other byte -> DROP.
  - PRE: dv=1, rxd=0x55, count<7 -> stay, count++. dv=1, rxd=0xD5 -> DATA. Any other byte, or an 8th 0x55 -> DROP. dv=0 -> IDLE silently, no eop.
  - DATA: every dv=1 cycle captures a byte: len++ (saturating), CRC updated.
    - dv=0 ends the frame and moves to END.
  - END: single cycle. Issues rx_eop, rx_err and rx_len. Increments good_cnt or bad_cnt. Re-initialises CRC and len, then goes to IDLE.
  - DROP: wait for dv=0, then IDLE. No output, no counter change.
- CRC: reflected CRC-32, LSB-first, polynomial 0xEDB88320, init 0xFFFFFFFF. Computed over DA through FCS inclusive. Good residue is 0xDEBB20E3.
- rx_err = (residue != 0xDEBB20E3) | (len < MIN_LEN) | (len > MAX_LEN).
- Oversize frames keep streaming bytes; the error is reported only at eop.
- Output timing (default): each captured byte appears on rx_data/rx_valid 1 cycle after capture. FCS bytes are passed through. rx_sop is set on the first byte after SFD.
- rx_eop timing: asserted the cycle after the last rx_valid byte (= END cycle, 1 cycle after dv falls).
- Back-to-back frames: dv may rise in the END cycle. That byte is evaluated as IDLE input in the same cycle, so no byte is lost.
- Frame with zero bytes after SFD: eop with len=0, rx_err=1, bad_cnt++.
- Counters hold at 0xFFFF.

Optional Feature:
RX_STRIP_FCS_EN
- Defined:
  - A 4-byte delay line withholds the last four bytes. Byte k is emitted the cycle after byte k+4 is captured, so FCS is never output.
  - rx_sop goes on the first emitted byte.
  - rx_len and CRC checking are unchanged (FCS included).
  - rx_eop timing is unchanged (cycle after dv falls).
  - Frames of 4 bytes or fewer emit no data bytes, only eop.
- Undefined: FCS is passed through as above, with 1-cycle latency.

Decomposition:
- Package gmii_rx_pkg holds:
  - state enum (IDLE, PRE, DATA, END, DROP)
  - constants PREAMBLE_BYTE=0x55, SFD_BYTE=0xD5
  - CRC_INIT=0xFFFFFFFF, CRC_POLY=0xEDB88320, CRC_RESIDUE=0xDEBB20E3
  - LEN_W=11, CNT_W=16
- One sub-module, crc32_d8: combinational next-CRC from 8-bit data and current CRC. It is reused by the future TX framer.

Test Plan:
- 7x0x55, 0xD5, then a 64-byte frame with correct FCS -> 64 rx_valid bytes, sop on first, eop 1 cycle after dv falls, rx_err=0, rx_len=64, good_cnt=1.
- Same frame with one payload bit flipped -> rx_err=1, rx_len=64, bad_cnt=1, good_cnt unchanged.
- 60-byte frame with valid CRC -> rx_err=1 (runt). 1519-byte frame -> rx_err=1, rx_len=1519.
- Preamble 0x55,0x55,0x12 then 70 bytes -> no rx_valid, no eop, counters unchanged. dv dropping after 3x0x55 -> same.
- Two good 64-byte frames, second dv rising in the END cycle of the first -> two eops, good_cnt=2, no byte lost.
- RX_STRIP_FCS_EN defined, good 64-byte frame -> exactly 60 rx_valid bytes, last = byte 60, eop cycle after dv falls, rx_len=64. Separately, rst_n low mid-frame -> all outputs 0 immediately, next frame received normally.
